// File: rtl/matrix_add_engine.sv
// -----------------------------------------------------------------------------
// matrix_add_engine
//   Memory-master sequencer for the matrix-add flow. On an accepted start it
//   reads matrix A and matrix B (each N_ELEM lanes of ELEM_W bits, 256b total)
//   from main memory, adds them lane by lane and writes the result back to the
//   destination slot. Integer slots are plain 256b words and use the same path.
//
//   Optional build macro:
//     MATRIX_ADD_SAT_EN - lanes clamp to all-ones on carry-out instead of
//                         wrapping modulo 2^ELEM_W. ovf is reported either way.
//
// Ports
//   Clk      in   1    clock, rising edge
//   nReset   in   1    asynchronous active-low reset
//   start    in   1    operation request, sampled only while idle
//   srcA     in   4    slot of operand A
//   srcB     in   4    slot of operand B
//   dst      in   4    slot receiving the result
//   busy     out  1    high from the cycle after accept until back in idle
//   done     out  1    one-cycle pulse once the write-back has been committed
//   ovf      out  1    OR of all lane carries, valid with done, held until
//                      the next accepted start
//   address  out  16   {MEM_SEL, 8'h00, slot}
//   nRead    out  1    active-low memory read strobe
//   nWrite   out  1    active-low memory write strobe
//   DataIn   in   256  memory read data (1-cycle latency after the read edge)
//   DataOut  out  256  memory write data
// -----------------------------------------------------------------------------
module matrix_add_engine #(
   parameter logic [3:0] MEM_SEL = 4'h0,
   parameter int          ELEM_W  = 16,
   parameter int          N_ELEM  = 16   // N_ELEM*ELEM_W must equal 256
) (
   input  logic         Clk,
   input  logic         nReset,
   input  logic         start,
   input  logic [3:0]   srcA,
   input  logic [3:0]   srcB,
   input  logic [3:0]   dst,
   output logic         busy,
   output logic         done,
   output logic         ovf,
   output logic [15:0]  address,
   output logic         nRead,
   output logic         nWrite,
   input  logic [255:0] DataIn,
   output logic [255:0] DataOut
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      WT_A = 3'd2,
      RD_B = 3'd3,
      WT_B = 3'd4,
      ADD  = 3'd5,
      WR   = 3'd6,
      DONE = 3'd7
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic           accept_s;
   logic [15:0]    address_nxt_s;
   logic           nread_nxt_s;
   logic           nwrite_nxt_s;
   logic           busy_nxt_s;
   logic           done_nxt_s;

   logic [3:0]     srcb_r;
   logic [3:0]     dst_r;
   logic [255:0]   rega_r;
   logic [255:0]   regb_r;
   logic [255:0]   sum_r;
   logic [255:0]   sum_nxt_s;
   logic           carry_any_s;
   logic [ELEM_W:0] lane_s;

   // One lane of the adder; the extra top bit is the lane carry-out.
   function automatic logic [ELEM_W:0] lane_add(input logic [ELEM_W-1:0] a,
                                                input logic [ELEM_W-1:0] b);
      lane_add = {1'b0, a} + {1'b0, b};
   endfunction

   // Next-state and next-output decode. Strobes and address are produced one
   // state early so that the registered outputs line up with the state they
   // belong to. srcA is taken straight from the port on accept because RD_A
   // is only ever entered from IDLE.
   always_comb begin
      state_nxt_s   = state_r;
      accept_s      = 1'b0;
      address_nxt_s = address;
      nread_nxt_s   = 1'b1;
      nwrite_nxt_s  = 1'b1;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s   = RD_A;
               accept_s      = 1'b1;
               address_nxt_s = {MEM_SEL, 8'h00, srcA};
               nread_nxt_s   = 1'b0;
            end else begin
               state_nxt_s   = IDLE;
            end
         end
         RD_A: state_nxt_s = WT_A;
         WT_A: begin
            state_nxt_s   = RD_B;
            address_nxt_s = {MEM_SEL, 8'h00, srcb_r};
            nread_nxt_s   = 1'b0;
         end
         RD_B: state_nxt_s = WT_B;
         WT_B: state_nxt_s = ADD;
         ADD: begin
            state_nxt_s   = WR;
            address_nxt_s = {MEM_SEL, 8'h00, dst_r};
            nwrite_nxt_s  = 1'b0;
         end
         WR:      state_nxt_s = DONE;
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
      busy_nxt_s = (state_nxt_s != IDLE);
      done_nxt_s = (state_nxt_s == DONE);
   end

   // Lane-wise add of the captured operands plus the OR of all carries.
   always_comb begin
      sum_nxt_s   = '0;
      carry_any_s = 1'b0;
      lane_s      = '0;
      for (int i = 0; i < N_ELEM; i++) begin
         lane_s      = lane_add(rega_r[i*ELEM_W +: ELEM_W], regb_r[i*ELEM_W +: ELEM_W]);
         carry_any_s = carry_any_s | lane_s[ELEM_W];
`ifdef MATRIX_ADD_SAT_EN
         if (lane_s[ELEM_W]) begin
            sum_nxt_s[i*ELEM_W +: ELEM_W] = {ELEM_W{1'b1}};
         end else begin
            sum_nxt_s[i*ELEM_W +: ELEM_W] = lane_s[ELEM_W-1:0];
         end
`else
         sum_nxt_s[i*ELEM_W +: ELEM_W] = lane_s[ELEM_W-1:0];
`endif
      end
   end

   // FSM state and registered memory-bus / status outputs.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_r <= IDLE;
         address <= 16'h0000;
         nRead   <= 1'b1;
         nWrite  <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         address <= address_nxt_s;
         nRead   <= nread_nxt_s;
         nWrite  <= nwrite_nxt_s;
         busy    <= busy_nxt_s;
         done    <= done_nxt_s;
      end
   end

   // Operand slots latched at accept so later port changes cannot disturb
   // the running operation.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         srcb_r <= 4'h0;
         dst_r  <= 4'h0;
      end else if (accept_s) begin
         srcb_r <= srcB;
         dst_r  <= dst;
      end
   end

   // Operand capture: read data is valid during the wait state after the read.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         rega_r <= '0;
         regb_r <= '0;
      end else if (state_r == WT_A) begin
         rega_r <= DataIn;
      end else if (state_r == WT_B) begin
         regb_r <= DataIn;
      end
   end

   // Result and overflow: computed in ADD; ovf is cleared on the next accept.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         sum_r <= '0;
         ovf   <= 1'b0;
      end else if (state_r == ADD) begin
         sum_r <= sum_nxt_s;
         ovf   <= carry_any_s;
      end else if (accept_s) begin
         ovf   <= 1'b0;
      end
   end

   assign DataOut = sum_r;

endmodule

// File: tb/tb_matrix_add_engine.sv
// -----------------------------------------------------------------------------
// tb_matrix_add_engine
//   Directed bench for matrix_add_engine with a behavioural 16-slot main
//   memory (1-cycle read latency, write committed on the nWrite edge).
//   A table of {operand patterns, expected result pattern, expected ovf}
//   records is applied in a loop; hand-written sequences cover default
//   memory, in-place add, held start and reset during the write cycle.
//   Lane patterns are linear: lane i = base + i*step (mod 2^16).
// -----------------------------------------------------------------------------
module tb_matrix_add_engine;

   logic         Clk = 1'b0;
   logic         nReset;
   logic         start;
   logic [3:0]   srcA;
   logic [3:0]   srcB;
   logic [3:0]   dst;
   logic         busy;
   logic         done;
   logic         ovf;
   logic [15:0]  address;
   logic         nRead;
   logic         nWrite;
   logic [255:0] DataIn;
   logic [255:0] DataOut;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   matrix_add_engine dut (
      .Clk     (Clk),
      .nReset  (nReset),
      .start   (start),
      .srcA    (srcA),
      .srcB    (srcB),
      .dst     (dst),
      .busy    (busy),
      .done    (done),
      .ovf     (ovf),
      .address (address),
      .nRead   (nRead),
      .nWrite  (nWrite),
      .DataIn  (DataIn),
      .DataOut (DataOut)
   );

   // Behavioural main memory; preload port used by the bench while idle.
   logic [255:0] mem [16];
   logic         pre_we = 1'b0;
   logic [3:0]   pre_slot = 4'h0;
   logic [255:0] pre_data = '0;
   logic [255:0] rdata;

   always @(posedge Clk) begin
      if (pre_we) mem[pre_slot] <= pre_data;
      else if (!nWrite && address[15:12] == 4'h0) mem[address[3:0]] <= DataOut;
      if (!nRead && address[15:12] == 4'h0) rdata <= mem[address[3:0]];
   end
   assign DataIn = rdata;

   typedef struct packed {
      logic [3:0]  sa;
      logic [3:0]  sb;
      logic [3:0]  sd;
      logic [15:0] a_base;
      logic [15:0] a_step;
      logic [15:0] b_base;
      logic [15:0] b_step;
      logic [15:0] e_base;
      logic [15:0] e_step;
      logic        e_ovf;
   } vec_t;

   vec_t vecs [5];

   function automatic logic [255:0] pat(input logic [15:0] base, input logic [15:0] step);
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[i*16 +: 16] = base + step * 16'(i);
      return v;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bus();
      chk("addr_sel", address[15:12], 4'h0);
      chk("addr_pad", address[11:4], 8'h00);
      chk("strobe_overlap", (!nRead && !nWrite), 1'b0);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
      check_bus();
   endtask

   task automatic preload(input logic [3:0] slot, input logic [255:0] data);
      @(negedge Clk);
      pre_we   = 1'b1;
      pre_slot = slot;
      pre_data = data;
      @(negedge Clk);
      pre_we   = 1'b0;
   endtask

   // One operation; k counts edges from the accepting edge (k=0).
   task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic exp_ovf);
      logic [7:0] nr, nw, dn, bz;
      @(negedge Clk);
      srcA  = a;
      srcB  = b;
      dst   = d;
      start = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         nr[k] = nRead;
         nw[k] = nWrite;
         dn[k] = done;
         bz[k] = busy;
         if (k == 0) begin
            start = 1'b0;
            srcA  = ~a;
            srcB  = ~b;
            dst   = ~d;
            chk("rd_a_addr", address, {4'h0, 8'h00, a});
            chk("ovf_clear_on_accept", ovf, 1'b0);
         end
         if (k == 2) chk("rd_b_addr", address, {4'h0, 8'h00, b});
         if (k == 5) chk("wr_addr", address, {4'h0, 8'h00, d});
         if (k == 6) chk("ovf_with_done", ovf, exp_ovf);
      end
      chk("nread_seq", nr, 8'b1111_1010);
      chk("nwrite_seq", nw, 8'b1101_1111);
      chk("done_seq", dn, 8'b0100_0000);
      chk("busy_seq", bz, 8'b0111_1111);
   endtask

   initial begin
      logic [255:0] w;
      int nr_cnt, nw_cnt, dn_cnt;

      // { sa, sb, sd, a_base, a_step, b_base, b_step, e_base, e_step, e_ovf }
      vecs[0] = {4'd3,  4'd4,  4'd5,  16'h0001, 16'h0001, 16'h0010, 16'h0010, 16'h0011, 16'h0011, 1'b0};
`ifdef MATRIX_ADD_SAT_EN
      vecs[1] = {4'd8,  4'd9,  4'd10, 16'hFFFF, 16'h0000, 16'h0002, 16'h0000, 16'hFFFF, 16'h0000, 1'b1};
      vecs[2] = {4'd6,  4'd7,  4'd11, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1};
`else
      vecs[1] = {4'd8,  4'd9,  4'd10, 16'hFFFF, 16'h0000, 16'h0002, 16'h0000, 16'h0001, 16'h0000, 1'b1};
      vecs[2] = {4'd6,  4'd7,  4'd11, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
`endif
      // Top lane lands exactly on 16'hFFFF without carry.
      vecs[3] = {4'd12, 4'd13, 4'd2,  16'hFFF0, 16'h0000, 16'h0000, 16'h0001, 16'hFFF0, 16'h0001, 1'b0};
      vecs[4] = {4'd14, 4'd15, 4'd13, 16'h1234, 16'h0100, 16'h4321, 16'h0001, 16'h5555, 16'h0101, 1'b0};

      nReset = 1'b0;
      start  = 1'b0;
      srcA   = 4'h0;
      srcB   = 4'h0;
      dst    = 4'h0;

      // Memory defaults: slot0 = 4+i, slot1 = 8, other slots = {slot,8'h00}+i.
      for (int s = 0; s < 16; s++) begin
         if (s == 0)      preload(4'(s), pat(16'h0004, 16'h0001));
         else if (s == 1) preload(4'(s), pat(16'h0008, 16'h0000));
         else             preload(4'(s), pat({4'h0, 4'(s), 8'h00}, 16'h0001));
      end

      // Reset state.
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_nread", nRead, 1'b1);
      chk("rst_nwrite", nWrite, 1'b1);
      chk("rst_address", address, 16'h0000);
      chk("rst_dataout", DataOut, 256'h0);

      @(negedge Clk);
      nReset = 1'b1;
      tick();
      tick();

      // Default memory: slot0 + slot1 -> slot2.
      run_op(4'd0, 4'd1, 4'd2, 1'b0);
      w = mem[2];
      chk("t1_lane0", w[15:0], 16'h000C);
      chk("t1_lane15", w[255:240], 16'h001B);
      chk("t1_slot2", w, pat(16'h000C, 16'h0001));

      // In place: slot0 = slot0 + slot1.
      run_op(4'd0, 4'd1, 4'd0, 1'b0);
      w = mem[0];
      chk("t3_lane0", w[15:0], 16'h000C);
      chk("t3_slot0", w, pat(16'h000C, 16'h0001));
      chk("t3_slot1_kept", mem[1], pat(16'h0008, 16'h0000));

      // Table-driven vectors.
      for (int v = 0; v < 5; v++) begin
         preload(vecs[v].sa, pat(vecs[v].a_base, vecs[v].a_step));
         preload(vecs[v].sb, pat(vecs[v].b_base, vecs[v].b_step));
         run_op(vecs[v].sa, vecs[v].sb, vecs[v].sd, vecs[v].e_ovf);
         chk($sformatf("vec%0d_result", v), mem[vecs[v].sd], pat(vecs[v].e_base, vecs[v].e_step));
         tick();
         tick();
         tick();
         chk($sformatf("vec%0d_ovf_hold", v), ovf, vecs[v].e_ovf);
      end

      // start held high: exactly two back-to-back in-place ops on slot3.
      nr_cnt = 0;
      nw_cnt = 0;
      dn_cnt = 0;
      @(negedge Clk);
      srcA  = 4'd3;
      srcB  = 4'd4;
      dst   = 4'd3;
      start = 1'b1;
      for (int k = 0; k < 18; k++) begin
         tick();
         if (!nRead)  nr_cnt++;
         if (!nWrite) nw_cnt++;
         if (done)    dn_cnt++;
         if (k == 7) chk("t4_idle_gap_busy", busy, 1'b0);
         if (k == 8) begin
            chk("t4_second_accept_busy", busy, 1'b1);
            chk("t4_second_accept_nread", nRead, 1'b0);
            start = 1'b0;
         end
      end
      chk("t4_read_count", nr_cnt, 4);
      chk("t4_write_count", nw_cnt, 2);
      chk("t4_done_count", dn_cnt, 2);
      chk("t4_busy_end", busy, 1'b0);
      chk("t4_slot3", mem[3], pat(16'h0021, 16'h0021));

      // Reset asserted in the WR cycle: write must not happen.
      @(negedge Clk);
      srcA  = 4'd0;
      srcB  = 4'd1;
      dst   = 4'd9;
      start = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 0) start = 1'b0;
      end
      chk("t5_in_wr", nWrite, 1'b0);
      nReset = 1'b0;
      #1;
      chk("t5_busy", busy, 1'b0);
      chk("t5_nwrite", nWrite, 1'b1);
      chk("t5_nread", nRead, 1'b1);
      chk("t5_done", done, 1'b0);
      chk("t5_address", address, 16'h0000);
      @(posedge Clk);
      #1;
      @(negedge Clk);
      nReset = 1'b1;
      tick();
      tick();
      chk("t5_dst_kept", mem[9], pat(16'h0002, 16'h0000));
      chk("t5_idle_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
